stopwatch: RTL and testbench

Four-digit BCD MM:SS stopwatch that steps once per `tick` enable, counting up or down under `sign`. It sits between a prescaler that generates `tick` and a display driver that consumes `digit`. `pulse` flags each step and each digit rollover so downstream logic can react without decoding digits.

---
 rtl/stopwatch_pkg.sv | 8 +
 rtl/stopwatch_bcd_digit.sv | 27 ++
 rtl/stopwatch.sv | 56 +++++
 tb/tb_stopwatch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
package packs;
  typedef logic [3:0] BCDnumber_t;

  localparam int DIGITS = 4;
  // Index 0 is seconds units, index 3 is minutes tens.
  localparam BCDnumber_t DIGIT_MAX [DIGITS] = '{4'd9, 4'd5, 4'd9, 4'd5};
endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD digit counting up or down between 0 and MAX; wrap flags the carry/borrow out.
module bcd_digit
  import packs::*;
#(
  parameter BCDnumber_t MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       down,
  output BCDnumber_t value,
  output logic       wrap
);

  // Combinational so the whole carry chain settles within one step.
  assign wrap = en && (down ? (value == 4'd0) : (value == MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= 4'd0;
    end else if (en) begin
      if (down) value <= (value == 4'd0) ? MAX : value - 4'd1;
      else      value <= (value == MAX) ? 4'd0 : value + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch.sv
// Four-digit MM:SS stopwatch with registered step/rollover strobes.
// Optional saturation at 59:59 / 00:00 when STOPWATCH_SAT_EN is defined.
module stopwatch
  import packs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sign,
  output BCDnumber_t digit [DIGITS],
  output logic       pulse [DIGITS+1]
);

  logic en   [DIGITS];
  logic wrap [DIGITS];

`ifdef STOPWATCH_SAT_EN
  // At the limit for the current direction the step is suppressed entirely.
  logic at_limit;
  always_comb begin
    at_limit = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit[i] != (sign ? 4'd0 : DIGIT_MAX[i])) at_limit = 1'b0;
    end
  end
  assign en[0] = tick && !at_limit;
`else
  assign en[0] = tick;
`endif

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi > 0) begin : g_chain
        assign en[gi] = en[gi-1] && wrap[gi-1];
      end
      bcd_digit #(.MAX(DIGIT_MAX[gi])) u_digit (
        .clk   (clk),
        .rst   (rst),
        .en    (en[gi]),
        .down  (sign),
        .value (digit[gi]),
        .wrap  (wrap[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= DIGITS; i++) pulse[i] <= 1'b0;
    end else begin
      pulse[0] <= en[0];
      for (int i = 0; i < DIGITS; i++) pulse[i+1] <= wrap[i];
    end
  end

endmodule

// File: tb/tb_stopwatch.sv
// Randomized and directed bench for stopwatch against a seconds-count reference model.
module tb_stopwatch;
  import packs::*;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       sign;
  BCDnumber_t digit [DIGITS];
  logic       pulse [DIGITS+1];

  int passed = 0;
  int total  = 0;

  // Reference: elapsed seconds 0..3599 and expected strobes.
  int         model_t = 0;
  logic [4:0] model_p = '0;

  stopwatch dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .sign  (sign),
    .digit (digit),
    .pulse (pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] got_digits();
    return {digit[3], digit[2], digit[1], digit[0]};
  endfunction

  function automatic logic [4:0] got_pulse();
    return {pulse[4], pulse[3], pulse[2], pulse[1], pulse[0]};
  endfunction

  function automatic logic [15:0] exp_digits();
    int m, s;
    m = model_t / 60;
    s = model_t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void step_model(input logic t, input logic s);
    model_p = '0;
    if (!t) return;
`ifdef STOPWATCH_SAT_EN
    if ((!s && model_t == 3599) || (s && model_t == 0)) return;
`endif
    model_p[0] = 1'b1;
    if (!s) begin
      model_p[1] = (model_t % 10)   == 9;
      model_p[2] = (model_t % 60)   == 59;
      model_p[3] = (model_t % 600)  == 599;
      model_p[4] = (model_t % 3600) == 3599;
      model_t    = (model_t + 1) % 3600;
    end else begin
      model_p[1] = (model_t % 10)   == 0;
      model_p[2] = (model_t % 60)   == 0;
      model_p[3] = (model_t % 600)  == 0;
      model_p[4] = (model_t % 3600) == 0;
      model_t    = (model_t + 3599) % 3600;
    end
  endfunction

  task automatic drive(input logic t, input logic s);
    @(negedge clk);
    tick = t;
    sign = s;
    @(posedge clk);
    #1;
    step_model(t, s);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    model_t = 0;
    model_p = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick = 1'b0; sign = 1'b0;
    #1;
    total++;
    if (got_digits() !== 16'h0 || got_pulse() !== 5'h0) begin
      $display("FAIL reset_initial digits=%h pulse=%b required digits=0000 pulse=00000", got_digits(), got_pulse());
    end else passed++;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    // Assert reset mid-cycle while pulses are high; clearing must be immediate.
    #2;
    tick = 1'b1;
    rst  = 1'b0;
    model_t = 0;
    model_p = '0;
    #1;
    total++;
    if (got_digits() !== 16'h0 || got_pulse() !== 5'h0) begin
      $display("FAIL reset_async digits=%h pulse=%b required digits=0000 pulse=00000", got_digits(), got_pulse());
    end else passed++;
    $display("reset_async digits=%h pulse=%b", got_digits(), got_pulse());
    @(posedge clk); #1;
    total++;
    if (got_digits() !== 16'h0 || got_pulse() !== 5'h0) begin
      $display("FAIL reset_hold digits=%h pulse=%b required digits=0000 pulse=00000", got_digits(), got_pulse());
    end else passed++;
    @(negedge clk); rst = 1'b1; tick = 1'b0;
    @(posedge clk); #1;
    total++;
    if (got_digits() !== 16'h0 || got_pulse() !== 5'h0) begin
      $display("FAIL reset_release digits=%h pulse=%b required digits=0000 pulse=00000", got_digits(), got_pulse());
    end else passed++;
    drive(1'b1, 1'b0);
    total++;
    if (got_digits() !== exp_digits() || got_pulse() !== model_p) begin
      $display("FAIL reset_first_tick digits=%h pulse=%b required digits=%h pulse=%b", got_digits(), got_pulse(), exp_digits(), model_p);
    end else passed++;
  endtask

  task automatic test_up_count();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0);
      total++;
      if (got_digits() !== exp_digits() || got_pulse() !== model_p) begin
        $display("FAIL up_count step=%0d digits=%h pulse=%b required digits=%h pulse=%b", i, got_digits(), got_pulse(), exp_digits(), model_p);
      end else passed++;
    end
    total++;
    if (got_digits() !== 16'h0010 || got_pulse() !== 5'b00011) begin
      $display("FAIL up_count_final digits=%h pulse=%b required digits=0010 pulse=00011", got_digits(), got_pulse());
    end else passed++;
    $display("up_count digits=%h pulse=%b", got_digits(), got_pulse());
  endtask

  task automatic test_minute_carry();
    apply_reset();
    for (int i = 0; i < 59; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    total++;
    if (got_digits() !== exp_digits() || got_pulse() !== model_p) begin
      $display("FAIL minute_carry digits=%h pulse=%b required digits=%h pulse=%b", got_digits(), got_pulse(), exp_digits(), model_p);
    end else passed++;
    total++;
    if (got_digits() !== 16'h0100 || got_pulse() !== 5'b00111) begin
      $display("FAIL minute_carry_const digits=%h pulse=%b required digits=0100 pulse=00111", got_digits(), got_pulse());
    end else passed++;
    $display("minute_carry digits=%h pulse=%b", got_digits(), got_pulse());
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < 3599; i++) drive(1'b1, 1'b0);
    total++;
    if (got_digits() !== 16'h5959) begin
      $display("FAIL full_wrap_preload digits=%h required digits=5959", got_digits());
    end else passed++;
    drive(1'b1, 1'b0);
    total++;
    if (got_digits() !== exp_digits() || got_pulse() !== model_p) begin
      $display("FAIL full_wrap digits=%h pulse=%b required digits=%h pulse=%b", got_digits(), got_pulse(), exp_digits(), model_p);
    end else passed++;
    $display("full_wrap digits=%h pulse=%b", got_digits(), got_pulse());
  endtask

  task automatic test_down_count();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1);
      total++;
      if (got_digits() !== exp_digits() || got_pulse() !== model_p) begin
        $display("FAIL down_count step=%0d digits=%h pulse=%b required digits=%h pulse=%b", i, got_digits(), got_pulse(), exp_digits(), model_p);
      end else passed++;
      $display("down_count step=%0d digits=%h pulse=%b", i, got_digits(), got_pulse());
    end
  endtask

  task automatic test_idle_level();
    apply_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    total++;
    if (got_digits() !== 16'h0003 || got_pulse() !== 5'b00001) begin
      $display("FAIL level_enable digits=%h pulse=%b required digits=0003 pulse=00001", got_digits(), got_pulse());
    end else passed++;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, i[0]);
      total++;
      if (got_digits() !== exp_digits() || got_pulse() !== 5'h0) begin
        $display("FAIL idle cycle=%0d digits=%h pulse=%b required digits=%h pulse=00000", i, got_digits(), got_pulse(), exp_digits());
      end else passed++;
    end
    $display("idle digits=%h pulse=%b", got_digits(), got_pulse());
  endtask

  task automatic test_random();
    logic t, s;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0);
      drive(t, s);
      total++;
      if (got_digits() !== exp_digits() || got_pulse() !== model_p) begin
        $display("FAIL random step=%0d tick=%b sign=%b digits=%h pulse=%b required digits=%h pulse=%b", i, t, s, got_digits(), got_pulse(), exp_digits(), model_p);
      end else passed++;
    end
    $display("random digits=%h pulse=%b", got_digits(), got_pulse());
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_minute_carry();
    test_full_wrap();
    test_down_count();
    test_idle_level();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
